// File: rtl/upsample_write_ctrl.sv
// Nearest-neighbour 2x upsampling write sequencer: one conv pixel in, a 2x2 block of OFM writes out.
// Optional UPSAMPLE_BYPASS_EN adds an upsample_mode port for one-write-per-pixel layers.
module upsample_write_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int OFM_SIZE_CONV = 13,
  parameter int NO_FILTER     = 128,
  parameter int ADDR_WIDTH    = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2*DATA_WIDTH-1:0] in_data,
`ifdef UPSAMPLE_BYPASS_EN
  input  logic                    upsample_mode,
`endif
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [2*DATA_WIDTH-1:0] wr_data,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = (OFM_SIZE_CONV > 1) ? $clog2(OFM_SIZE_CONV) : 1;
  localparam int FW = (NO_FILTER > 1) ? $clog2(NO_FILTER) : 1;
  localparam logic [ADDR_WIDTH-1:0] OS     = ADDR_WIDTH'(2 * OFM_SIZE_CONV);
  localparam logic [CW-1:0]         C_LAST = CW'(OFM_SIZE_CONV - 1);
  localparam logic [FW-1:0]         F_LAST = FW'(NO_FILTER - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_WR0  = 3'd2;
  localparam logic [2:0] S_WR1  = 3'd3;
  localparam logic [2:0] S_WR2  = 3'd4;
  localparam logic [2:0] S_WR3  = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]            state;
  logic [CW-1:0]         col, row;
  logic [FW-1:0]         filt;
  logic [ADDR_WIDTH-1:0] base;   // base address of the next pixel to be accepted
  logic                  last_q; // pixel currently being written is the last of the layer
  logic                  up_mode;
  logic                  hs, row_end, pix_last;
  logic [ADDR_WIDTH-1:0] step;

`ifdef UPSAMPLE_BYPASS_EN
  logic mode_q;
  assign up_mode = mode_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       mode_q <= 1'b1;
    else if (state == S_IDLE && start) mode_q <= upsample_mode;
  end
`else
  assign up_mode = 1'b1;
`endif

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    in_ready = 1'b0;
    case (state)
      S_WAIT:  in_ready = 1'b1;
      S_WR0:   in_ready = !up_mode && !last_q;
      S_WR3:   in_ready = !last_q;
      default: in_ready = 1'b0;
    endcase
    hs       = in_ready && in_valid;
    row_end  = (col == C_LAST);
    pix_last = row_end && (row == C_LAST) && (filt == F_LAST);
    if (!up_mode)     step = ADDR_WIDTH'(1);
    else if (row_end) step = OS + ADDR_WIDTH'(2); // skip the odd output row
    else              step = ADDR_WIDTH'(2);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col     <= '0;
      row     <= '0;
      filt    <= '0;
      base    <= '0;
      last_q  <= 1'b0;
      wr_data <= '0;
    end else if (state == S_IDLE && start) begin
      col    <= '0;
      row    <= '0;
      filt   <= '0;
      base   <= '0;
      last_q <= 1'b0;
    end else if (hs) begin
      wr_data <= in_data;
      base    <= base + step;
      last_q  <= pix_last;
      if (row_end) begin
        col <= '0;
        if (row == C_LAST) begin
          row  <= '0;
          filt <= filt + FW'(1);
        end else begin
          row <= row + CW'(1);
        end
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          state <= S_WAIT;
          busy  <= 1'b1;
        end
        S_WAIT: wr_en <= 1'b0;
        S_WR0: begin
          if (up_mode) begin
            wr_addr <= wr_addr + ADDR_WIDTH'(1);
            state   <= S_WR1;
          end else if (last_q) begin
            state <= S_DONE;
            wr_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_WAIT;
            wr_en <= 1'b0;
          end
        end
        S_WR1: begin
          wr_addr <= wr_addr + OS - ADDR_WIDTH'(1);
          state   <= S_WR2;
        end
        S_WR2: begin
          wr_addr <= wr_addr + ADDR_WIDTH'(1);
          state   <= S_WR3;
        end
        S_WR3: begin
          if (last_q) begin
            state <= S_DONE;
            wr_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state <= S_WAIT;
            wr_en <= 1'b0;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      // An accepted pixel overrides the fall-back to WAIT and starts a new block.
      if (hs) begin
        state   <= S_WR0;
        wr_en   <= 1'b1;
        wr_addr <= base;
      end
    end
  end

endmodule

// File: tb/tb_upsample_write_ctrl.sv
// Scoreboard bench for upsample_write_ctrl with C=2, F=2: expected writes are queued at each
// accepted pixel from an address formula and compared as the DUT writes.
module tb_upsample_write_ctrl;

  localparam int DW = 8;
  localparam int C  = 2;
  localparam int F  = 2;
  localparam int AW = 5;
  localparam int OS = 2 * C;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            start = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [2*DW-1:0] in_data = '0;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [2*DW-1:0] wr_data;
  logic            busy;
  logic            done;
  logic            mode_bit = 1'b1;

  upsample_write_ctrl #(
    .DATA_WIDTH(DW), .OFM_SIZE_CONV(C), .NO_FILTER(F), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data),
`ifdef UPSAMPLE_BYPASS_EN
    .upsample_mode(mode_bit),
`endif
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   addr;
    logic [2*DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  pix_k = 0;
  int  wr_cnt = 0;
  int  last_addr = -1;
  int  first_addr = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop on every write, push the block for every accepted pixel.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        check("sb_has_entry", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", wr_addr, e.addr);
          check("wr_data", wr_data, e.data);
        end
        wr_cnt++;
        last_addr = int'(wr_addr);
        if (first_addr < 0) first_addr = int'(wr_addr);
      end
      if (in_valid && in_ready) begin
        int f, r, c, b;
        f = pix_k / (C * C);
        r = (pix_k / C) % C;
        c = pix_k % C;
        if (mode_bit) begin
          b = f * OS * OS + 2 * r * OS + 2 * c;
          exp_q.push_back('{AW'(b), in_data});
          exp_q.push_back('{AW'(b + 1), in_data});
          exp_q.push_back('{AW'(b + OS), in_data});
          exp_q.push_back('{AW'(b + OS + 1), in_data});
        end else begin
          exp_q.push_back('{AW'(pix_k), in_data});
        end
        pix_k++;
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_data"}, wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_in_ready"}, in_ready, 0);
  endtask

  // gap=0 holds in_valid high; otherwise in_valid rises every gap cycles and holds until accepted.
  task automatic run_layer(input int gap, input bit restart_mid, input int exp_cycles,
                           input int exp_writes, input int exp_last);
    int  cyc;
    int  data_v;
    bit  hs;
    exp_q.delete();
    pix_k = 0;
    wr_cnt = 0;
    first_addr = -1;
    last_addr = -1;
    data_v = 5;
    @(posedge clk); #1;
    start = 1'b1;
    in_data = 16'(data_v);
    in_valid = (gap == 0);
    cyc = 0;
    while (cyc < 2000) begin
      @(negedge clk);
      if (cyc == 1) check("busy_rise", busy, 1);
      if (done) break;
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      start = restart_mid && (cyc == 20);
      if (hs) begin
        data_v++;
        in_data = 16'(data_v);
        if (gap != 0) in_valid = 1'b0;
      end
      if (gap != 0 && (cyc % gap) == 0) in_valid = 1'b1;
    end
    check("done_seen", done, 1);
    if (gap == 0) check("latency", cyc, exp_cycles);
    check("busy_at_done", busy, 0);
    check("write_count", wr_cnt, exp_writes);
    check("first_addr", first_addr, 0);
    check("last_addr", last_addr, exp_last);
    check("sb_empty", exp_q.size(), 0);
    in_valid = 1'b0;
    @(negedge clk);
    check("done_pulse_end", done, 0);
    check("idle_in_ready", in_ready, 0);
  endtask

  initial begin
    bit found;
    #3 rst_n = 1'b0;
    #1 check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Full-rate layer: 32 writes, done 1 + 4*C*C*F + 1 cycles after start.
    run_layer(0, 1'b0, 34, 32, 31);

    // Stalled upstream plus a spurious start mid-layer.
    run_layer(9, 1'b1, 0, 32, 31);

    // Asynchronous reset while the first block is in WR2.
    exp_q.delete();
    pix_k = 0;
    @(posedge clk); #1;
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h00aa;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (wr_en && wr_addr == AW'(OS)) found = 1'b1;
    end
    check("reach_wr2", found, 1);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("mid_reset");
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
    run_layer(0, 1'b0, 34, 32, 31);

`ifdef UPSAMPLE_BYPASS_EN
    mode_bit = 1'b0;
    run_layer(0, 1'b0, 10, 8, 7);
    mode_bit = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
